// File: rtl/rr_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_reg_arbiter_if
// Description : Request/grant and shared-register bus between the producer
//               blocks and the round-robin register arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_reg_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N-1:0]         req;
    logic [N*WIDTH-1:0]   wdata;
    logic [N-1:0]         gnt;
    logic [WIDTH-1:0]     Q;
    logic                 done;
    logic [$clog2(N)-1:0] done_id;
    logic                 busy;

    modport master (
        output req, wdata,
        input  gnt, Q, done, done_id, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, Q, done, done_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_reg_arbiter
// Description : Round-robin arbiter sharing one WIDTH-bit register among N
//               requesters; grant one cycle, commit the owner's data the next.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_reg_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    rr_reg_arbiter_if.slave  bus
);
    localparam int         c_IDW   = $clog2(N);
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [c_IDW-1:0] r_ptr;
    logic [c_IDW-1:0] r_owner;
    logic [c_IDW-1:0] r_done_id;
    logic [N-1:0]     r_gnt;
    logic [WIDTH-1:0] r_q;
    logic             r_done;

    logic [2*N-1:0]   w_req2;
    logic [N-1:0]     w_rot;
    logic [c_IDW:0]   w_sum;
    logic [c_IDW-1:0] w_winner;
    logic             w_found;
    logic             w_grant;
    logic             w_commit;
    logic [N-1:0]     w_onehot;
    logic [c_IDW-1:0] w_ptr_nxt;
    logic [WIDTH-1:0] w_wdata_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign w_wdata_arr[gi] = bus.wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotate requests so bit 0 is the ptr position; the lowest set bit wins.
    assign w_req2 = {bus.req, bus.req};
    assign w_rot  = N'(w_req2 >> r_ptr);

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (c_IDW+1)'(k);
                if (w_sum >= (c_IDW+1)'(N)) begin
                    w_sum = w_sum - (c_IDW+1)'(N);
                end
                w_winner = w_sum[c_IDW-1:0];
            end
        end
    end

    assign w_onehot  = N'(1) << w_winner;
    assign w_ptr_nxt = (r_owner == c_IDW'(N - 1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = c_GRANT;
                end
            end
            c_GRANT: begin
                w_commit    = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // The commit is unconditional once granted; wdata is sampled at the commit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_gnt     <= '0;
            r_q       <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_grant ? w_onehot : '0;
            r_done  <= w_commit;
            if (w_grant) begin
                r_owner <= w_winner;
            end
            if (w_commit) begin
                r_q       <= w_wdata_arr[r_owner];
                r_done_id <= r_owner;
                r_ptr     <= w_ptr_nxt;
            end
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.Q       = r_q;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.busy    = (r_state == c_GRANT);
endmodule
`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_reg_arbiter
// Description : Self-checking bench for rr_reg_arbiter: directed scenarios plus
//               random traffic scored against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_reg_arbiter;
    localparam int N     = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rr_reg_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();
    rr_reg_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model state (updated at posedge, read by the monitor at negedge)
    int  m_ptr = 0;
    int  m_pend = -1;
    int  m_q = 0;
    int  m_done_id = 0;
    bit  m_exp_gnt = 1'b0;
    bit  m_exp_done = 1'b0;
    int  gq[$];
    int  cq_id[$];
    int  cq_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [N*WIDTH-1:0] wd;
        int w;
        wd = bus.wdata;
        if (reset) begin
            m_ptr = 0; m_pend = -1; m_q = 0; m_done_id = 0;
            m_exp_gnt = 1'b0; m_exp_done = 1'b0;
        end else if (m_pend >= 0) begin
            m_q = int'(wd[m_pend*WIDTH +: WIDTH]);
            m_done_id = m_pend;
            cq_id.push_back(m_pend);
            cq_data.push_back(m_q);
            m_ptr = (m_pend + 1) % N;
            m_pend = -1;
            m_exp_gnt = 1'b0;
            m_exp_done = 1'b1;
        end else begin
            m_exp_done = 1'b0;
            w = pick(bus.req, m_ptr);
            m_exp_gnt = (w >= 0);
            if (w >= 0) begin
                gq.push_back(w);
                m_pend = w;
            end
        end
    end

    always @(negedge clk) begin
        int e;
        chk("busy_eq_or_gnt", 32'(bus.busy), 32'(|bus.gnt));
        chk("gnt_active", 32'(bus.gnt != '0), 32'(m_exp_gnt));
        if (bus.gnt != '0) begin
            e = (gq.size() > 0) ? gq.pop_front() : -1;
            chk("gnt_onehot", 32'(bus.gnt), (e < 0) ? 32'hFFFF_FFFF : (32'd1 << e));
        end
        chk("done_pulse", 32'(bus.done), 32'(m_exp_done));
        if (bus.done) begin
            e = (cq_id.size() > 0) ? cq_id.pop_front() : -1;
            chk("commit_id", 32'(bus.done_id), 32'(e));
            e = (cq_data.size() > 0) ? cq_data.pop_front() : -1;
            chk("commit_data", 32'(bus.Q), 32'(e));
        end
        chk("q_value", 32'(bus.Q), 32'(m_q));
        chk("done_id_hold", 32'(bus.done_id), 32'(m_done_id));
    end

    task automatic wait_gnt(input logic [N-1:0] exp, input string name);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) break;
        end
        chk(name, 32'(bus.gnt), 32'(exp));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        bus.req   = 4'b1111;
        bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};

        // Reset held two cycles with all requests high
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_q", 32'(bus.Q), 32'h00);
            chk("rst_gnt", 32'(bus.gnt), 32'h0);
            chk("rst_done", 32'(bus.done), 32'h0);
            chk("rst_busy", 32'(bus.busy), 32'h0);
        end
        reset = 1'b0;
        wait_gnt(4'b0001, "first_gnt_after_reset");
        bus.req = 4'b0000;
        idle(3);

        // Single write from requester 0 (ptr becomes 1 after the write above)
        reset = 1'b1; idle(1); reset = 1'b0;
        bus.wdata[7:0] = 8'hA5;
        bus.req = 4'b0001;
        wait_gnt(4'b0001, "single_gnt");
        bus.req = 4'b0000;
        @(negedge clk);
        chk("single_q", 32'(bus.Q), 32'hA5);
        chk("single_done", 32'(bus.done), 32'h1);
        chk("single_done_id", 32'(bus.done_id), 32'h0);
        idle(1);
        bus.req = 4'b0011;
        wait_gnt(4'b0010, "ptr_after_single");
        bus.req = 4'b0000;
        idle(2);

        // Rotation from a fresh reset
        reset = 1'b1; idle(1); reset = 1'b0;
        bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(4'b0001 << (k % 4), "rot_gnt");
            @(negedge clk);
            chk("rot_q", 32'(bus.Q), 32'h10 + 32'(k % 4));
            chk("rot_done_id", 32'(bus.done_id), 32'(k % 4));
        end
        bus.req = 4'b0000;
        idle(2);

        // Wrap-around: write from 2 leaves ptr=3, then 0 must beat 1
        bus.req = 4'b0100;
        wait_gnt(4'b0100, "wrap_setup");
        bus.req = 4'b0000;
        idle(2);
        bus.req = 4'b0011;
        wait_gnt(4'b0001, "wrap_to_zero");
        bus.req = 4'b0010;
        wait_gnt(4'b0010, "wrap_then_one");
        bus.req = 4'b0000;
        idle(2);

        // Reset in the grant cycle
        reset = 1'b1; idle(1); reset = 1'b0;
        bus.wdata[23:16] = 8'h5A;
        bus.req = 4'b0100;
        wait_gnt(4'b0100, "midrst_gnt");
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_q", 32'(bus.Q), 32'h00);
        chk("midrst_done", 32'(bus.done), 32'h0);
        chk("midrst_gnt", 32'(bus.gnt), 32'h0);
        reset = 1'b0;
        wait_gnt(4'b0100, "midrst_regrant");
        bus.req = 4'b0000;
        @(negedge clk);
        chk("midrst_commit", 32'(bus.Q), 32'h5A);
        idle(1);

        // Data changed and req dropped during the grant cycle
        bus.wdata[15:8] = 8'h33;
        bus.req = 4'b0010;
        wait_gnt(4'b0010, "sample_gnt");
        bus.wdata[15:8] = 8'h77;
        bus.req = 4'b0000;
        @(negedge clk);
        chk("sample_q", 32'(bus.Q), 32'h77);
        chk("sample_done", 32'(bus.done), 32'h1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_regrant", 32'(bus.gnt), 32'h0);
        end

        // Random traffic obeying the requester contract
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && bus.gnt[i]) begin
                    bus.wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    bus.req[i] = ($urandom_range(0, 3) == 0);
                end else if (!bus.req[i]) begin
                    bus.wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    bus.req[i] = ($urandom_range(0, 2) == 0);
                end
            end
        end
        reset = 1'b0;
        bus.req = '0;
        idle(4);
        chk("grant_queue_drained", 32'(gq.size()), 32'h0);
        chk("commit_queue_drained", 32'(cq_id.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
